ble_pdu_decoder: RTL and testbench
==================================

Name: ble_pdu_decoder

Overview:
Parametrised successor to the byte-level packet decoder in the BLE sniffer receive path. It sits after the access-address correlator and byte assembler. It de-whitens per bit using the BLE x^7+x^4+1 LFSR seeded from the channel index, parses the 2-byte PDU header, and streams payload bytes with first/last framing. It runs a real CRC-24 over header and payload, compares it against the received CRC, and reports per-packet status, including length-error and abort detection.

Parameters:
MAX_PAYLOAD, 255, largest legal payload length; larger header lengths flag len_err.
LEN_W, 8, width of the header length field and of the payload byte counter.
CRC_POLY, 24'h00065B, CRC-24 polynomial without the x^24 term.
STATS_W, 16, width of the statistics counters (used only with PKT_STATS_EN).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pkt_start  in  1  single-cycle pulse from the correlator: access address matched, next byte is header byte 0
chan_idx  in  6  RF channel index 0..39, sampled on pkt_start
crc_init  in  24  CRC seed (24'h555555 for advertising), sampled on pkt_start
data_in  in  8  received byte; first air bit is in bit 0
data_valid  in  1  data_in is valid this cycle
pdu_byte  out  8  de-whitened header or payload byte
pdu_valid  out  1  pdu_byte is valid
pdu_first  out  1  asserted with header byte 0
pdu_last  out  1  asserted with the final payload byte, or with header byte 1 when length is 0
hdr_type  out  4  header byte 0 bits [3:0], held until the next pkt_start
hdr_len  out  LEN_W  header byte 1, held until the next pkt_start
pkt_done  out  1  single-cycle pulse: packet finished; crc_ok and len_err are valid
crc_ok  out  1  computed CRC equals received CRC
len_err  out  1  hdr_len exceeded MAX_PAYLOAD
pkt_abort  out  1  single-cycle pulse: pkt_start arrived while busy
busy  out  1  state is not IDLE
state  out  3  current FSM state, for debug

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. Reset asserted mid-packet discards the packet and produces no pkt_done.
- FSM states: IDLE=0, HDR0=1, HDR1=2, PAYLOAD=3, CRC=4, DONE=5.
- In states HDR0 through CRC, exactly one byte is consumed per data_valid cycle. data_valid is ignored in IDLE and DONE.
- Latency: outputs are registered; pdu_byte, pdu_valid, first and last appear one cycle after the consuming edge.
- IDLE plus pkt_start:
  - Load LFSR with lfsr[0]=1 and lfsr[k]=chan_idx[6-k] for k=1..6.
  - Load crc=crc_init and clear the byte counter.
  - Go to HDR0.
- Whitening, per bit, LSB first: out = in ^ lfsr[6]; then lfsr <= {lfsr[5:0], lfsr[6]} with the new bit 4 XORed with lfsr[6]. The LFSR advances 8 steps per consumed byte, including CRC bytes.
- CRC, over the de-whitened header and payload bits in air order: fb = bit ^ crc[23]; crc <= {crc[22:0],1'b0} ^ (fb ? CRC_POLY : 0). CRC bytes are not fed into the CRC.
- HDR0: emit the byte with pdu_first=1, latch hdr_type, go to HDR1.
- HDR1: emit the byte and latch hdr_len.
  - len > MAX_PAYLOAD: set len_err=1, crc_ok=0, pulse pkt_done next cycle, go to IDLE. No further bytes are emitted.
  - len == 0: pdu_last=1, go to CRC.
  - Otherwise go to PAYLOAD.
- PAYLOAD: emit each byte. pdu_last=1 on byte len-1, then go to CRC. The counter is LEN_W+1 bits wide, so it never wraps at len=255.
- CRC: consume 3 bytes without emitting them. The i-th received CRC bit (i=0..23, air order) must equal crc[23-i]. After the third byte go to DONE.
- DONE: pulse pkt_done for one cycle with crc_ok and len_err valid, then go to IDLE. crc_ok and len_err hold until the next pkt_start.
- pkt_start in any non-IDLE state: pulse pkt_abort, emit no pkt_done for the old packet, and reseed and go to HDR0 in the same cycle.
- pkt_start and data_valid in the same cycle in IDLE: the byte is ignored.

Optional Feature:
PKT_STATS_EN
- Defined: adds input stats_clr and outputs pkt_cnt, crc_err_cnt, len_err_cnt, each STATS_W wide.
  - Counters saturate at all-ones.
  - pkt_cnt increments on each pkt_done; crc_err_cnt when pkt_done has crc_ok=0 and len_err=0; len_err_cnt on len_err.
  - stats_clr has priority over increments in the same cycle.
- Undefined: these ports and counters do not exist.

Decomposition:
- Package ble_pkg: FSM state enum, CRC_POLY_DEFAULT, ADV_CRC_INIT=24'h555555, HDR_BYTES=2, CRC_BYTES=3, LFSR seed function.
- Sub-module ble_byte_lfsr_crc: combinational 8-bit unrolled whitening step and CRC step. Inputs are byte, lfsr and crc; outputs are de-whitened byte, next lfsr and next crc. It is reused by the future transmit-side whitener.

Test Plan:
- Channel 37, crc_init 555555, len 6 ADV packet built by the bench model -> 8 pdu_valid bytes, pdu_first on byte 0, pdu_last on byte 7, pkt_done with crc_ok=1 and len_err=0.
- Same packet with one CRC bit flipped -> pkt_done with crc_ok=0; with PKT_STATS_EN, crc_err_cnt=1 and pkt_cnt=1.
- Length 0 packet on channel 0 -> 2 bytes emitted, pdu_last on header byte 1, pkt_done exactly 4 consuming cycles after HDR1 plus 1.
- MAX_PAYLOAD=37, header len 38 -> len_err=1, pkt_done one cycle after HDR1, no payload bytes emitted, FSM back in IDLE.
- pkt_start injected during PAYLOAD byte 3 -> pkt_abort pulse, no pkt_done for the old packet, the new packet decodes with crc_ok=1.
- len=255 with gapped data_valid, plus rst_n asserted mid-CRC on a second packet -> first packet completes with crc_ok=1; after reset all outputs are 0 and state=IDLE.

Source files
------------

// File: rtl/ble_pkg.sv
// Shared types and constants for the BLE PDU decoder: FSM encoding, CRC-24
// constants, framing sizes and the channel-index whitening seed.
package ble_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR0    = 3'd1,
    ST_HDR1    = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CRC     = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam logic [23:0] CRC_POLY_DEFAULT = 24'h00065B;
  localparam logic [23:0] ADV_CRC_INIT     = 24'h555555;
  localparam int          HDR_BYTES        = 2;
  localparam int          CRC_BYTES        = 3;

  // lfsr[0] is always 1; lfsr[k] takes chan[6-k], so chan bit 0 lands in lfsr[6].
  function automatic logic [6:0] lfsr_seed(input logic [5:0] chan);
    lfsr_seed = {chan[0], chan[1], chan[2], chan[3], chan[4], chan[5], 1'b1};
  endfunction

  // Received CRC bits arrive MSB-first in air order, i.e. crc[23] in byte bit 0.
  function automatic logic [7:0] crc_air_byte(input logic [23:0] crc);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[j] = crc[23-j];
    crc_air_byte = b;
  endfunction

endpackage

// File: rtl/ble_byte_lfsr_crc.sv
// One byte of BLE de-whitening (x^7+x^4+1) and CRC-24 update, unrolled over
// 8 air bits, LSB first. Purely combinational; shared with the TX whitener.
module ble_byte_lfsr_crc
  import ble_pkg::*;
#(
  parameter logic [23:0] CRC_POLY = CRC_POLY_DEFAULT
) (
  input  logic [7:0]  byte_i,
  input  logic [6:0]  lfsr_i,
  input  logic [23:0] crc_i,
  output logic [7:0]  byte_o,
  output logic [6:0]  lfsr_o,
  output logic [23:0] crc_o
);

  logic [6:0]  l;
  logic [23:0] c;
  logic [7:0]  b;
  logic        fb;

  always_comb begin
    l  = lfsr_i;
    c  = crc_i;
    b  = '0;
    fb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b[i] = byte_i[i] ^ l[6];
      fb   = b[i] ^ c[23];
      c    = {c[22:0], 1'b0} ^ (fb ? CRC_POLY : 24'd0);
      // Rotate left; the bit shifted into position 4 also takes the feedback tap.
      l    = {l[5:4], l[3] ^ l[6], l[2:0], l[6]};
    end
    byte_o = b;
    lfsr_o = l;
    crc_o  = c;
  end

endmodule

// File: rtl/ble_pdu_decoder.sv
// BLE PDU decoder: de-whitens, frames header/payload, checks CRC-24 and reports
// per-packet status. Define PKT_STATS_EN to add saturating packet statistics.
// Stream contract: data_valid qualifies data_in with no backpressure; every
// data_valid cycle in HDR0..CRC consumes exactly one byte, pdu_valid is a
// one-cycle strobe with no ready, and pkt_start always wins over data_valid.
module ble_pdu_decoder
  import ble_pkg::*;
#(
  parameter int          MAX_PAYLOAD = 255,
  parameter int          LEN_W       = 8,
  parameter logic [23:0] CRC_POLY    = CRC_POLY_DEFAULT,
  parameter int          STATS_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pkt_start,
  input  logic [5:0]       chan_idx,
  input  logic [23:0]      crc_init,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  output logic [7:0]       pdu_byte,
  output logic             pdu_valid,
  output logic             pdu_first,
  output logic             pdu_last,
  output logic [3:0]       hdr_type,
  output logic [LEN_W-1:0] hdr_len,
  output logic             pkt_done,
  output logic             crc_ok,
  output logic             len_err,
  output logic             pkt_abort,
`ifdef PKT_STATS_EN
  input  logic               stats_clr,
  output logic [STATS_W-1:0] pkt_cnt,
  output logic [STATS_W-1:0] crc_err_cnt,
  output logic [STATS_W-1:0] len_err_cnt,
`endif
  output logic             busy,
  output logic [2:0]       state
);

  localparam int CNT_W = LEN_W + 1;

  state_e           state_q, state_d;
  logic [6:0]       lfsr_q, lfsr_d;
  logic [23:0]      crc_q, crc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             crc_bad_q, crc_bad_d;
  logic [7:0]       pdu_byte_q, pdu_byte_d;
  logic             pdu_valid_q, pdu_valid_d;
  logic             pdu_first_q, pdu_first_d;
  logic             pdu_last_q, pdu_last_d;
  logic [3:0]       hdr_type_q, hdr_type_d;
  logic [LEN_W-1:0] hdr_len_q, hdr_len_d;
  logic             pkt_done_q, pkt_done_d;
  logic             crc_ok_q, crc_ok_d;
  logic             len_err_q, len_err_d;
  logic             pkt_abort_q, pkt_abort_d;

  logic [7:0]       dw_byte;
  logic [6:0]       lfsr_nx;
  logic [23:0]      crc_nx;
  logic [LEN_W-1:0] len_rx;
  logic [CNT_W-1:0] cnt_inc;

  ble_byte_lfsr_crc #(
    .CRC_POLY (CRC_POLY)
  ) u_step (
    .byte_i (data_in),
    .lfsr_i (lfsr_q),
    .crc_i  (crc_q),
    .byte_o (dw_byte),
    .lfsr_o (lfsr_nx),
    .crc_o  (crc_nx)
  );

  assign len_rx  = LEN_W'(dw_byte);
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    crc_bad_d   = crc_bad_q;
    pdu_byte_d  = pdu_byte_q;
    pdu_valid_d = 1'b0;
    pdu_first_d = 1'b0;
    pdu_last_d  = 1'b0;
    hdr_type_d  = hdr_type_q;
    hdr_len_d   = hdr_len_q;
    pkt_done_d  = 1'b0;
    crc_ok_d    = crc_ok_q;
    len_err_d   = len_err_q;
    pkt_abort_d = 1'b0;

    if (pkt_start) begin
      pkt_abort_d = (state_q != ST_IDLE);
      lfsr_d      = lfsr_seed(chan_idx);
      crc_d       = crc_init;
      cnt_d       = '0;
      crc_bad_d   = 1'b0;
      hdr_type_d  = '0;
      hdr_len_d   = '0;
      crc_ok_d    = 1'b0;
      len_err_d   = 1'b0;
      state_d     = ST_HDR0;
    end else begin
      case (state_q)
        ST_HDR0: if (data_valid) begin
          pdu_byte_d  = dw_byte;
          pdu_valid_d = 1'b1;
          pdu_first_d = 1'b1;
          hdr_type_d  = dw_byte[3:0];
          lfsr_d      = lfsr_nx;
          crc_d       = crc_nx;
          state_d     = ST_HDR1;
        end
        ST_HDR1: if (data_valid) begin
          pdu_byte_d  = dw_byte;
          pdu_valid_d = 1'b1;
          hdr_len_d   = len_rx;
          lfsr_d      = lfsr_nx;
          crc_d       = crc_nx;
          cnt_d       = '0;
          if ({1'b0, len_rx} > CNT_W'(MAX_PAYLOAD)) begin
            len_err_d  = 1'b1;
            crc_ok_d   = 1'b0;
            pkt_done_d = 1'b1;
            state_d    = ST_IDLE;
          end else if (len_rx == '0) begin
            pdu_last_d = 1'b1;
            state_d    = ST_CRC;
          end else begin
            state_d    = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: if (data_valid) begin
          pdu_byte_d  = dw_byte;
          pdu_valid_d = 1'b1;
          lfsr_d      = lfsr_nx;
          crc_d       = crc_nx;
          cnt_d       = cnt_inc;
          if (cnt_inc == {1'b0, hdr_len_q}) begin
            pdu_last_d = 1'b1;
            cnt_d      = '0;
            state_d    = ST_CRC;
          end
        end
        ST_CRC: if (data_valid) begin
          // The CRC register is shifted out a byte at a time for comparison.
          lfsr_d    = lfsr_nx;
          crc_d     = {crc_q[15:0], 8'h00};
          crc_bad_d = crc_bad_q | (dw_byte != crc_air_byte(crc_q));
          cnt_d     = cnt_inc;
          if (cnt_q == CNT_W'(CRC_BYTES - 1)) state_d = ST_DONE;
        end
        ST_DONE: begin
          pkt_done_d = 1'b1;
          crc_ok_d   = ~crc_bad_q;
          len_err_d  = 1'b0;
          state_d    = ST_IDLE;
        end
        ST_IDLE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lfsr_q      <= '0;
      crc_q       <= '0;
      cnt_q       <= '0;
      crc_bad_q   <= 1'b0;
      pdu_byte_q  <= '0;
      pdu_valid_q <= 1'b0;
      pdu_first_q <= 1'b0;
      pdu_last_q  <= 1'b0;
      hdr_type_q  <= '0;
      hdr_len_q   <= '0;
      pkt_done_q  <= 1'b0;
      crc_ok_q    <= 1'b0;
      len_err_q   <= 1'b0;
      pkt_abort_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      crc_bad_q   <= crc_bad_d;
      pdu_byte_q  <= pdu_byte_d;
      pdu_valid_q <= pdu_valid_d;
      pdu_first_q <= pdu_first_d;
      pdu_last_q  <= pdu_last_d;
      hdr_type_q  <= hdr_type_d;
      hdr_len_q   <= hdr_len_d;
      pkt_done_q  <= pkt_done_d;
      crc_ok_q    <= crc_ok_d;
      len_err_q   <= len_err_d;
      pkt_abort_q <= pkt_abort_d;
    end
  end

`ifdef PKT_STATS_EN
  logic [STATS_W-1:0] pkt_cnt_q, crc_err_cnt_q, len_err_cnt_q;

  // Counters sample the registered status pulse, so they lag pkt_done by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q     <= '0;
      crc_err_cnt_q <= '0;
      len_err_cnt_q <= '0;
    end else if (stats_clr) begin
      pkt_cnt_q     <= '0;
      crc_err_cnt_q <= '0;
      len_err_cnt_q <= '0;
    end else if (pkt_done_q) begin
      if (pkt_cnt_q != '1) pkt_cnt_q <= pkt_cnt_q + STATS_W'(1);
      if (!crc_ok_q && !len_err_q && crc_err_cnt_q != '1)
        crc_err_cnt_q <= crc_err_cnt_q + STATS_W'(1);
      if (len_err_q && len_err_cnt_q != '1)
        len_err_cnt_q <= len_err_cnt_q + STATS_W'(1);
    end
  end

  assign pkt_cnt     = pkt_cnt_q;
  assign crc_err_cnt = crc_err_cnt_q;
  assign len_err_cnt = len_err_cnt_q;
`endif

  assign pdu_byte  = pdu_byte_q;
  assign pdu_valid = pdu_valid_q;
  assign pdu_first = pdu_first_q;
  assign pdu_last  = pdu_last_q;
  assign hdr_type  = hdr_type_q;
  assign hdr_len   = hdr_len_q;
  assign pkt_done  = pkt_done_q;
  assign crc_ok    = crc_ok_q;
  assign len_err   = len_err_q;
  assign pkt_abort = pkt_abort_q;
  assign busy      = (state_q != ST_IDLE);
  assign state     = state_q;

endmodule

// File: tb/tb_ble_pdu_decoder.sv
// Bench for ble_pdu_decoder: two instances (MAX_PAYLOAD 255 and 37) share one
// randomized air stream; a packet-level model feeds expected-event queues.
module tb_ble_pdu_decoder;
  import ble_pkg::*;

  localparam int W      = 16;
  localparam int MAXP_B = 37;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pkt_start, data_valid;
  logic [5:0]  chan_idx;
  logic [23:0] crc_init;
  logic [7:0]  data_in;

  logic [7:0] a_byte, b_byte, a_len, b_len;
  logic [3:0] a_type, b_type;
  logic [2:0] a_state, b_state;
  logic a_valid, a_first, a_last, a_done, a_ok, a_le, a_abort, a_busy;
  logic b_valid, b_first, b_last, b_done, b_ok, b_le, b_abort, b_busy;
`ifdef PKT_STATS_EN
  logic        stats_clr;
  logic [15:0] a_pkt_cnt, a_crc_cnt, a_len_cnt, b_pkt_cnt, b_crc_cnt, b_len_cnt;
`endif

  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  logic [7:0]   pdu_q[$];
  logic [7:0]   air_q[$];
  bit           busy_m[2];
  int           exp_pkt[2], exp_crc[2], exp_len[2];
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  ble_pdu_decoder #(.MAX_PAYLOAD(255), .LEN_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .pkt_start(pkt_start), .chan_idx(chan_idx),
    .crc_init(crc_init), .data_in(data_in), .data_valid(data_valid),
    .pdu_byte(a_byte), .pdu_valid(a_valid), .pdu_first(a_first), .pdu_last(a_last),
    .hdr_type(a_type), .hdr_len(a_len), .pkt_done(a_done), .crc_ok(a_ok),
    .len_err(a_le), .pkt_abort(a_abort),
`ifdef PKT_STATS_EN
    .stats_clr(stats_clr), .pkt_cnt(a_pkt_cnt), .crc_err_cnt(a_crc_cnt), .len_err_cnt(a_len_cnt),
`endif
    .busy(a_busy), .state(a_state)
  );

  ble_pdu_decoder #(.MAX_PAYLOAD(MAXP_B), .LEN_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .pkt_start(pkt_start), .chan_idx(chan_idx),
    .crc_init(crc_init), .data_in(data_in), .data_valid(data_valid),
    .pdu_byte(b_byte), .pdu_valid(b_valid), .pdu_first(b_first), .pdu_last(b_last),
    .hdr_type(b_type), .hdr_len(b_len), .pkt_done(b_done), .crc_ok(b_ok),
    .len_err(b_le), .pkt_abort(b_abort),
`ifdef PKT_STATS_EN
    .stats_clr(stats_clr), .pkt_cnt(b_pkt_cnt), .crc_err_cnt(b_crc_cnt), .len_err_cnt(b_len_cnt),
`endif
    .busy(b_busy), .state(b_state)
  );

  // ---------------- reference model ----------------
  function automatic int maxp(input int u);
    return (u == 0) ? 255 : MAXP_B;
  endfunction

  function automatic int model_seed(input int chan);
    int l = 1;
    for (int k = 1; k <= 6; k++) if (((chan >> (6 - k)) & 1) == 1) l += (1 << k);
    return l;
  endfunction

  function automatic logic [23:0] model_crc(input logic [23:0] init);
    int c = int'(init);
    int fb;
    foreach (pdu_q[i]) begin
      for (int j = 0; j < 8; j++) begin
        fb = ((pdu_q[i] >> j) & 1) ^ ((c >> 23) & 1);
        c  = (c << 1) & 'hFFFFFF;
        if (fb == 1) c = c ^ int'(CRC_POLY_DEFAULT);
      end
    end
    return 24'(c);
  endfunction

  function automatic void model_whiten(input int chan);
    int l = model_seed(chan);
    int msb;
    logic [7:0] t;
    foreach (air_q[i]) begin
      t = air_q[i];
      for (int j = 0; j < 8; j++) begin
        msb  = (l >> 6) & 1;
        t[j] = t[j] ^ msb[0];
        l    = ((l << 1) & 127) | msb;
        if (msb == 1) l = l ^ 16;
      end
      air_q[i] = t;
    end
  endfunction

  function automatic logic [W-1:0] ev_byte(input logic f, input logic l, input logic [7:0] b);
    return {2'd0, 4'd0, f, l, b};
  endfunction

  function automatic logic [W-1:0] ev_done(input logic [3:0] t, input logic ok, input logic le,
                                           input logic [7:0] len);
    return {2'd1, t, ok, le, len};
  endfunction

  function automatic logic [W-1:0] ev_abort();
    return {2'd2, 14'd0};
  endfunction

  function automatic void push_exp(input int u, input logic [W-1:0] ev);
    if (u == 0) exp_a_q.push_back(ev);
    else        exp_b_q.push_back(ev);
  endfunction

  function automatic void push_done(input int u, input logic [3:0] t, input logic ok,
                                    input logic le, input logic [7:0] len);
    push_exp(u, ev_done(t, ok, le, len));
    exp_pkt[u]++;
    if (le) exp_len[u]++;
    else if (!ok) exp_crc[u]++;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic check_evt(input int u, input logic [W-1:0] got);
    logic [W-1:0] exp;
    total++;
    if ((u == 0 && exp_a_q.size() == 0) || (u == 1 && exp_b_q.size() == 0)) begin
      bad++;
      $display("FAIL unexpected_evt_u%0d got=%h required=none", u, got);
      return;
    end
    if (u == 0) exp = exp_a_q.pop_front();
    else        exp = exp_b_q.pop_front();
    if (got !== exp) begin
      bad++;
      $display("FAIL evt_u%0d got=%h required=%h", u, got, exp);
    end
  endtask

  task automatic mon_unit(input int u, input logic ab, input logic v, input logic f,
                          input logic l, input logic [7:0] b, input logic d, input logic ok,
                          input logic le, input logic [3:0] t, input logic [7:0] len);
    if (ab) check_evt(u, ev_abort());
    if (v)  check_evt(u, ev_byte(f, l, b));
    if (d)  check_evt(u, ev_done(t, ok, le, len));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon_unit(0, a_abort, a_valid, a_first, a_last, a_byte, a_done, a_ok, a_le, a_type, a_len);
      mon_unit(1, b_abort, b_valid, b_first, b_last, b_byte, b_done, b_ok, b_le, b_type, b_len);
    end
  end

  // ---------------- drivers ----------------
  task automatic check_reset_outputs();
    chk("rst_out_a", {a_byte, a_valid, a_first, a_last, a_type, a_len, a_done, a_ok, a_le,
                      a_abort, a_busy, a_state}, 0);
    chk("rst_out_b", {b_byte, b_valid, b_first, b_last, b_type, b_len, b_done, b_ok, b_le,
                      b_abort, b_busy, b_state}, 0);
`ifdef PKT_STATS_EN
    chk("rst_stats", {a_pkt_cnt, a_crc_cnt, a_len_cnt, b_pkt_cnt}, 0);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    data_valid = 1'b0;
    pkt_start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    exp_a_q.delete();
    exp_b_q.delete();
    for (int u = 0; u < 2; u++) begin
      busy_m[u] = 0; exp_pkt[u] = 0; exp_crc[u] = 0; exp_len[u] = 0;
    end
    @(negedge clk);
    chk("post_rst_state_a", a_state, 0);
    chk("post_rst_state_b", b_state, 0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      data_valid = 1'($urandom_range(0, 1));
      data_in = 8'($urandom);
      @(posedge clk); #1;
    end
    data_valid = 1'b0;
  endtask

  task automatic run_packet(input int chan, input logic [23:0] init, input int len,
                            input bit flip, input int abort_at, input bit gaps, input bit rst_at_crc);
    logic [23:0] c;
    logic [7:0]  t;
    bit          alive[2];
    int          n = len + 5;
    pdu_q.delete();
    air_q.delete();
    pdu_q.push_back(8'($urandom));
    pdu_q.push_back(8'(len));
    for (int i = 0; i < len; i++) pdu_q.push_back(8'($urandom));
    c = model_crc(init);
    foreach (pdu_q[i]) air_q.push_back(pdu_q[i]);
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 8; j++) t[j] = c[23 - 8 * k - j];
      air_q.push_back(t);
    end
    if (flip) begin
      int fb = $urandom_range(0, 23);
      air_q[len + 2 + fb / 8] = air_q[len + 2 + fb / 8] ^ (8'd1 << (fb % 8));
    end
    model_whiten(chan);

    pkt_start = 1'b1;
    chan_idx = 6'(chan);
    crc_init = init;
    data_valid = 1'($urandom_range(0, 1));
    data_in = 8'($urandom);
    for (int u = 0; u < 2; u++) begin
      if (busy_m[u]) push_exp(u, ev_abort());
      busy_m[u] = 1;
      alive[u] = 1;
    end
    @(posedge clk); #1;
    pkt_start = 1'b0;
    data_valid = 1'b0;

    for (int i = 0; i < n; i++) begin
      if (i == abort_at) return;
      if (gaps) begin
        int g = $urandom_range(0, 2);
        repeat (g) begin
          data_valid = 1'b0; data_in = 8'($urandom);
          @(posedge clk); #1;
        end
      end
      if (rst_at_crc && i == len + 3) begin
        do_reset();
        return;
      end
      data_valid = 1'b1;
      data_in = air_q[i];
      for (int u = 0; u < 2; u++) begin
        if (alive[u]) begin
          if (i == 1 && len > maxp(u)) begin
            push_exp(u, ev_byte(1'b0, 1'b0, pdu_q[1]));
            push_done(u, pdu_q[0][3:0], 1'b0, 1'b1, 8'(len));
            alive[u] = 0;
            busy_m[u] = 0;
          end else if (i < len + 2) begin
            push_exp(u, ev_byte(i == 0, i == len + 1, pdu_q[i]));
          end else if (i == n - 1) begin
            push_done(u, pdu_q[0][3:0], !flip, 1'b0, 8'(len));
            busy_m[u] = 0;
          end
        end
      end
      @(posedge clk); #1;
      data_valid = 1'b0;
      if (i == 1 && len > MAXP_B) begin
        @(negedge clk);
        chk("lenerr_done_b", b_done, 1);
        chk("lenerr_idle_b", b_state, 0);
      end
    end
    @(negedge clk);
    chk("done_wait_a", {a_done, a_state}, {1'b0, 3'd5});
    @(negedge clk);
    chk("done_pulse_a", {a_done, a_state}, {1'b1, 3'd0});
    if (len <= MAXP_B) chk("done_pulse_b", b_done, 1);
    idle_cycles($urandom_range(1, 3));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; pkt_start = 1'b0; data_valid = 1'b0;
    chan_idx = '0; crc_init = '0; data_in = '0;
`ifdef PKT_STATS_EN
    stats_clr = 1'b0;
`endif
    for (int u = 0; u < 2; u++) begin
      busy_m[u] = 0; exp_pkt[u] = 0; exp_crc[u] = 0; exp_len[u] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk); #1;
`ifdef PKT_STATS_EN
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
`endif

    run_packet(37, ADV_CRC_INIT, 6, 0, -1, 0, 0);
    run_packet(37, ADV_CRC_INIT, 6, 1, -1, 0, 0);
    run_packet(0, ADV_CRC_INIT, 0, 0, -1, 0, 0);
    run_packet(21, 24'($urandom), 38, 0, -1, 0, 0);
    run_packet(12, 24'($urandom), 10, 0, 5, 0, 0);
    run_packet(20, 24'($urandom), 12, 0, -1, 0, 0);
    run_packet(12, 24'($urandom), 255, 0, -1, 1, 0);
    run_packet(5, 24'($urandom), 20, 0, -1, 1, 1);
    for (int k = 0; k < 25; k++) begin
      int len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 45);
      int ab  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len + 4) : -1;
      run_packet($urandom_range(0, 39), 24'($urandom), len, 1'($urandom_range(0, 3) == 0),
                 ab, 1'($urandom_range(0, 1)), 0);
    end
    run_packet(39, ADV_CRC_INIT, 3, 0, -1, 0, 0);

    idle_cycles(8);
    chk("drain_a", exp_a_q.size(), 0);
    chk("drain_b", exp_b_q.size(), 0);
`ifdef PKT_STATS_EN
    chk("pkt_cnt_a", a_pkt_cnt, exp_pkt[0]);
    chk("crc_cnt_a", a_crc_cnt, exp_crc[0]);
    chk("pkt_cnt_b", b_pkt_cnt, exp_pkt[1]);
    chk("len_cnt_b", b_len_cnt, exp_len[1]);
    chk("crc_cnt_b", b_crc_cnt, exp_crc[1]);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
